// File: rtl/comparison_pkg.sv
// comparison_pkg: predicate and FSM state encodings shared by the sequential comparator, ID decoder and bench
package comparison_pkg;
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LTU = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GTU = 3'd4,
    CMP_GT  = 3'd5
  } cmp_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_comparison_unit_if.sv
// seq_comparison_unit_if: operand/result valid-ready bundle of the sequential comparator
interface seq_comparison_unit_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             valid_o;
  logic             ready_i;
  logic             flag;
  modport master (output valid_i, a, b, sel, ready_i, input ready_o, valid_o, flag);
  modport slave  (input valid_i, a, b, sel, ready_i, output ready_o, valid_o, flag);
endinterface

// File: rtl/chunk_compare.sv
// chunk_compare: combinational CHUNK-bit unsigned equal / greater-than compare
module chunk_compare #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt
);
  assign eq = a == b;
  assign gt = a > b;
endmodule

// File: rtl/seq_comparison_unit.sv
// seq_comparison_unit: MSB-first multi-cycle branch comparator, CHUNK bits per cycle.
// Define SEQ_CMP_EARLY_EXIT_EN to leave CMP at the first differing chunk.
module seq_comparison_unit
  import comparison_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  seq_comparison_unit_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(NCHUNK) + 1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d, gt_q, gt_d, alive_q;
  logic             c_eq, c_gt, accept, last, sgn, res;
  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_q[WIDTH-1 -: CHUNK]),
    .b  (b_q[WIDTH-1 -: CHUNK]),
    .eq (c_eq),
    .gt (c_gt)
  );
  assign accept = bus.valid_i && bus.ready_o;
  assign last   = cnt_q == CW'(NCHUNK - 1) || (EARLY && !c_eq);
  // flipping the sign bit maps two's-complement order onto unsigned order
  assign sgn    = bus.sel == CMP_LT || bus.sel == CMP_GT;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? CMP : IDLE;
      CMP:     state_d = last ? DONE : CMP;
      default: state_d = bus.ready_i ? IDLE : DONE;
    endcase
  end
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    eq_d  = eq_q;
    gt_d  = gt_q;
    if (accept) begin
      a_d   = bus.a ^ {sgn, {(WIDTH-1){1'b0}}};
      b_d   = bus.b ^ {sgn, {(WIDTH-1){1'b0}}};
      sel_d = bus.sel;
      cnt_d = '0;
      eq_d  = 1'b1;
      gt_d  = 1'b0;
    end else if (state_q == CMP) begin
      a_d   = a_q << CHUNK;
      b_d   = b_q << CHUNK;
      cnt_d = cnt_q + 1'b1;
      if (eq_q && !c_eq) begin
        eq_d = 1'b0;
        gt_d = c_gt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      alive_q <= 1'b1;
    end
  end
  always_comb begin
    res = sel_q == CMP_EQ ? eq_q :
          sel_q == CMP_NE ? !eq_q :
          (sel_q == CMP_LTU || sel_q == CMP_LT) ? (!eq_q && !gt_q) :
          (sel_q == CMP_GTU || sel_q == CMP_GT) ? (!eq_q && gt_q) : 1'b0;
    bus.ready_o = alive_q && rst_n && state_q == IDLE;
    bus.valid_o = state_q == DONE;
    bus.flag    = state_q == DONE && res;
  end
endmodule

// File: doc/seq_comparison_unit.md
# seq_comparison_unit

Multi-cycle, parametrised branch-condition comparator for the ID stage. It compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and returns a one-bit condition flag for the six branch predicates. A valid/ready handshake sits on the operand input and on the result output. It replaces the single-cycle comparator wherever wide operands or timing closure need the compare split over several cycles.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; CHUNK == WIDTH gives one compare cycle. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- valid_i  input  1  operands and sel are valid.
- ready_o  output  1  unit can accept an operation (IDLE only).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  3  predicate: 0 eq, 1 ne, 2 ltu, 3 lt (signed), 4 gtu, 5 gt (signed), 6/7 reserved.
- valid_o  output  1  flag is valid.
- ready_i  input  1  consumer accepts the result.
- flag  output  1  predicate result.

## Operation
- States: IDLE, CMP, DONE.
- IDLE: ready_o=1. When valid_i&ready_o: capture a, b, sel; chunk index := 0; eq_so_far := 1; go to CMP.
- Signed predicates (3, 5): invert bit WIDTH-1 of both operands at capture. All compares are then unsigned.
- CMP: each cycle compares the current MSB-side CHUNK of a_r/b_r, then shifts both left by CHUNK.
  - At the first differing chunk, record gt_r := (a_chunk > b_chunk) and clear eq_so_far.
  - Go to DONE after the last chunk or, with early exit compiled in, at the first differing chunk.
- DONE: valid_o=1; flag is held stable.
  - Flag by predicate: eq = eq_so_far; ne = !eq_so_far; ltu/lt = !eq_so_far & !gt_r; gtu/gt = !eq_so_far & gt_r.
  - Return to IDLE on valid_o&ready_i.
- Reserved sel: follows normal sequencing; flag=0.
- Inputs a, b, sel are ignored outside the accept cycle.
- Reset (rst_n low at any edge, including mid-CMP or DONE): state := IDLE, valid_o=0, flag=0, internal registers cleared. The pending operation is discarded and no result is emitted.
- ready_o=0 on every cycle in which rst_n is low.

## Timing
- Reset values: ready_o=1 after the first edge with rst_n high, else 0; valid_o=0; flag=0.
- The accept edge is T. Chunk i (1-based, from MSB) is evaluated on edge T+i.
- Latency: valid_o rises after edge T+k.
  - k = NCHUNK without early exit.
  - k = index of the first differing chunk with early exit; k = NCHUNK if the operands are equal.
- Output handshake: the result transfers on the edge where valid_o&ready_i. valid_o drops and ready_o rises after that edge.
- Back-to-back operations: next accept is no earlier than edge T+k+2. There is no overlap of operations.
- Backpressure: while ready_i=0 in DONE, valid_o and flag stay constant indefinitely.

## Configuration
- SEQ_CMP_EARLY_EXIT_EN defined: CMP exits at the first differing chunk, giving variable latency 1..NCHUNK.
- SEQ_CMP_EARLY_EXIT_EN undefined: CMP always runs NCHUNK cycles, giving fixed latency. The flag value is identical in both builds.

## Structure
- Shared package comparison_pkg:
  - typedef enum for the predicate encodings CMP_EQ..CMP_GT with the 3-bit values above.
  - typedef enum for states IDLE/CMP/DONE.
  - Shared by the ID-stage decoder and the bench.
- Sub-module chunk_compare: combinational, CHUNK-bit unsigned compare, outputs eq and gt. Instantiated once on the MSB chunk of a_r/b_r.
- Chunk counter width: $clog2(NCHUNK)+1.

## Test plan
- Directed tests run with WIDTH=32, CHUNK=8.
- a=0x1000_0001, b=0x0000_0001, sel=ltu -> flag=0; valid_o after 1 cycle with macro, after 4 cycles without.
- a=b=0xDEAD_BEEF, sel=eq then sel=ne -> flag=1 then flag=0, each after 4 cycles in both builds.
- a=0xFFFF_FFFF, b=0x0000_0001 -> sel=lt gives flag=1; sel=ltu gives flag=0; sel=gt gives flag=0; sel=gtu gives flag=1.
- a=0x0000_0102, b=0x0000_0103, sel=gtu, ready_i=0 for 3 cycles after valid_o -> flag=0 held with valid_o=1 and ready_o=0; after handshake, ready_o=1 on the next cycle.
- Accept a=0x8000_0000, b=0 with sel=lt, then drive rst_n low for one edge at T+2 -> valid_o stays 0 and ready_o=1 after release; the following op a=5, b=5, sel=eq returns flag=1.
- sel=6 with any operands -> valid_o after normal latency, flag=0.
